// File: rtl/mod_addsub_sched_pkg.sv
// Shared definitions for the modular add/subtract scheduler.
//   W_DEFAULT  default operand/modulus width
//   OP_ADD/OP_SUB  request opcode encoding
//   state_e    scheduler FSM states
//   id_width() width of a requester index (at least 1 bit)
package mod_arith_pkg;

  localparam int unsigned W_DEFAULT = 256;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_RESP
  } state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_addsub_sched_if.sv
// Request/response bundle between the point-arithmetic units and the
// modular add/subtract scheduler.
//   req_valid/req_ready/req_op/req_a/req_b  per-requester request channel,
//                                           operands packed at [i*W +: W]
//   mod_p                                   modulus, stable while busy
//   rsp_valid/rsp_ready/rsp_id/rsp_data     single response channel
//   busy                                    scheduler not idle
// Modports: master = requesters/consumer side, slave = scheduler side.
interface mod_addsub_sched_if
  import mod_arith_pkg::*;
#(
  parameter int unsigned W    = W_DEFAULT,
  parameter int unsigned NREQ = 2
) ();

  localparam int unsigned IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      mod_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_op, req_a, req_b, mod_p, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, mod_p, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/mod_addsub_sched_wide_adder.sv
// wide_adder: the shared W-bit ripple-carry adder, organised as 8-bit
// ripple slices chained through their carries.
//   x, y  addends
//   cin   carry in
//   sum   W-bit sum
//   cout  carry out of bit W-1
module wide_adder #(
  parameter int unsigned W = 256
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = (W + SLICE - 1) / SLICE;

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      for (int unsigned k = 0; k < SLICE; k++) begin
        if (s * SLICE + k < W) begin
          sum[s*SLICE+k] = x[s*SLICE+k] ^ y[s*SLICE+k] ^ carry;
          carry = (x[s*SLICE+k] & y[s*SLICE+k]) |
                  (carry & (x[s*SLICE+k] ^ y[s*SLICE+k]));
        end
      end
    end
    cout = carry;
  end

endmodule

// File: rtl/mod_addsub_sched.sv
// mod_addsub_sched: time-shares one W-bit adder between NREQ requesters.
// Each request is (a +/- b) mod p, done as a raw pass followed by a
// correction pass by p; one response is returned per accepted request.
//   clk, rst  clock, asynchronous active-high reset
//   bus       mod_addsub_sched_if.slave (request, response, modulus, busy)
// Optional build macro MODADD_EARLY_EXIT_EN: a subtraction with no borrow
// skips the correction pass and responds one cycle earlier.
module mod_addsub_sched
  import mod_arith_pkg::*;
#(
  parameter int unsigned W    = W_DEFAULT,
  parameter int unsigned NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  mod_addsub_sched_if.slave   bus
);

  localparam int unsigned IDW = id_width(NREQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, s1_q, s1_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           op_q, op_d, c1_q, c1_d;

  logic [NREQ-1:0] rot;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx, rr_next;

  logic [W-1:0] add_x, add_y, add_sum;
  logic         add_cin, add_cout;

  // Round-robin: rotate valids so rr_ptr sits at bit 0, take the first set bit.
  always_comb begin
    int unsigned pos, nxt;
    pos       = 0;
    nxt       = 0;
    rot       = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_next   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_vld && rot[k]) begin
        grant_vld = 1'b1;
        pos = 32'(rr_ptr_q) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        nxt = pos + 1;
        if (nxt >= NREQ) nxt = 0;
        grant_idx = IDW'(pos);
        rr_next   = IDW'(nxt);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == ST_IDLE && grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

  // Adder operand mux by state.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      ST_PASS1: begin
        add_x   = a_q;
        add_y   = (op_q == OP_SUB) ? ~b_q : b_q;
        add_cin = (op_q == OP_SUB);
      end
      ST_PASS2: begin
        add_x   = s1_q;
        add_y   = (op_q == OP_SUB) ? bus.mod_p : ~bus.mod_p;
        add_cin = (op_q == OP_ADD);
      end
      default: ;
    endcase
  end

  wide_adder #(.W(W)) u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s1_d       = s1_q;
    c1_d       = c1_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
              a_d  = bus.req_a[i*W +: W];
              b_d  = bus.req_b[i*W +: W];
              op_d = bus.req_op[i];
            end
          end
          id_d     = grant_idx;
          rr_ptr_d = rr_next;
          state_d  = ST_PASS1;
        end
      end
      ST_PASS1: begin
        s1_d    = add_sum;
        c1_d    = add_cout;
        state_d = ST_PASS2;
`ifdef MODADD_EARLY_EXIT_EN
        if (op_q == OP_SUB && add_cout) begin
          rsp_data_d = add_sum;
          state_d    = ST_RESP;
        end
`endif
      end
      ST_PASS2: begin
        // s2/c2 are consumed straight off the adder; only the selected
        // result is registered, which is what RESP presents.
        if (op_q == OP_ADD) rsp_data_d = (c1_q | add_cout) ? add_sum : s1_q;
        else                rsp_data_d = c1_q ? s1_q : add_sum;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      s1_q       <= '0;
      c1_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s1_q       <= s1_d;
      c1_q       <= c1_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_addsub_sched.sv
// Self-checking bench for mod_addsub_sched: directed cases, contention,
// backpressure, mid-operation reset and randomized traffic, checked by a
// scoreboard against a plain-arithmetic reference model.
module tb_mod_addsub_sched;
  import mod_arith_pkg::*;

  localparam int unsigned W    = 256;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = id_width(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_addsub_sched_if #(.W(W), .NREQ(NREQ)) bus ();

  mod_addsub_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    int unsigned    acc;
    int unsigned    lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_acc    = 0;
  int unsigned rr       = 0;
  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic [IDW-1:0] prev_id    = '0;
  logic [W-1:0]   prev_data  = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // (a +/- b) mod p with a, b < p.
  function automatic logic [W-1:0] ref_op(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] p);
    logic [W:0] s;
    if (op == OP_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, p}) s = s - {1'b0, p};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, p} - {1'b0, b};
    end
    return s[W-1:0];
  endfunction

  function automatic int unsigned ref_lat(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
`ifdef MODADD_EARLY_EXIT_EN
    return (op == OP_SUB && a >= b) ? 2 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor / scoreboard. The DUT is expected idle exactly when nothing is
  // outstanding; an idle DUT grants the first valid requester at/after rr.
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] exp_rdy;
    int unsigned     j;
    exp_t            e;
    cyc++;
    if (rst) begin
      chk("rst_req_ready", W'(bus.req_ready), '0);
      chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
      chk("rst_rsp_id",    W'(bus.rsp_id),    '0);
      chk("rst_rsp_data",  bus.rsp_data,      '0);
      chk("rst_busy",      W'(bus.busy),      '0);
      sb.delete();
      rr         = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      exp_rdy = '0;
      if (sb.size() == 0) begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          j = (rr + k) % NREQ;
          if (exp_rdy == '0 && bus.req_valid[j]) exp_rdy[j] = 1'b1;
        end
      end
      chk("req_ready", W'(bus.req_ready), W'(exp_rdy));
      chk("busy", W'(bus.busy), W'(sb.size() != 0));
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", W'(bus.rsp_valid), W'(1'b1));
        chk("hold_id",    W'(bus.rsp_id),    W'(prev_id));
        chk("hold_data",  bus.rsp_data,      prev_data);
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response (t=%0t)",
                   bus.rsp_id, bus.rsp_data, $time);
        end else begin
          if (!prev_valid) chk("latency", W'(cyc - sb[0].acc), W'(sb[0].lat));
          if (bus.rsp_ready) begin
            chk("rsp_id",   W'(bus.rsp_id), W'(sb[0].id));
            chk("rsp_data", bus.rsp_data,   sb[0].data);
            void'(sb.pop_front());
          end
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (exp_rdy[i]) begin
          rr = (i + 1) % NREQ;
        end
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id   = IDW'(i);
          e.data = ref_op(bus.req_op[i], bus.req_a[i*W +: W], bus.req_b[i*W +: W], bus.mod_p);
          e.acc  = cyc;
          e.lat  = ref_lat(bus.req_op[i], bus.req_a[i*W +: W], bus.req_b[i*W +: W]);
          sb.push_back(e);
          n_acc++;
        end
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_id    = bus.rsp_id;
      prev_data  = bus.rsp_data;
    end
  end

  task automatic issue(input int unsigned i, input logic op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned t;
    t = 0;
    @(posedge clk); #1;
    bus.req_valid[i]     = 1'b1;
    bus.req_op[i]        = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[i] && t < 100);
    chk("grant_in_time", W'(bus.req_ready[i]), W'(1'b1));
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", W'(sb.size() != 0 || bus.busy), '0);
  endtask

  task automatic wait_acc(input int unsigned target);
    int unsigned t;
    t = 0;
    while (n_acc < target && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("accepts_in_time", W'(n_acc >= target), W'(1'b1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] p25519, pbig;
    logic [W-1:0] plist[3];
    p25519 = (W'(1) << 255) - W'(19);
    pbig   = '1 - W'(188);

    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.mod_p     = W'(97);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;

    // Directed: lone req1, small add, wrap-around adds, subtract with/without borrow.
    issue(1, OP_ADD, W'(10), W'(20));      drain();
    issue(0, OP_ADD, W'(5), W'(7));        drain();
    bus.mod_p = p25519;
    issue(0, OP_ADD, p25519 - 1, W'(2));   drain();
    issue(0, OP_ADD, p25519 - 1, p25519 - 1); drain();
    bus.mod_p = W'(97);
    issue(0, OP_SUB, W'(3), W'(5));        drain();
    issue(1, OP_SUB, W'(9), W'(4));        drain();

    // Contention: both held valid with constant ops.
    @(posedge clk); #1;
    bus.req_op          = 2'b10;
    bus.req_a[0 +: W]   = W'(50);
    bus.req_b[0 +: W]   = W'(60);
    bus.req_a[W +: W]   = W'(20);
    bus.req_b[W +: W]   = W'(70);
    bus.req_valid       = '1;
    wait_acc(n_acc + 8);
    #1;
    bus.req_valid = '0;
    drain();

    // Backpressure: response held 10 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    issue(0, OP_ADD, W'(40), W'(50));
    bus.req_op[1]     = OP_SUB;
    bus.req_a[W +: W] = W'(11);
    bus.req_b[W +: W] = W'(96);
    bus.req_valid[1]  = 1'b1;
    begin
      int unsigned t;
      t = 0;
      while (!bus.rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("rsp_valid_in_time", W'(bus.rsp_valid), W'(1'b1));
    end
    repeat (10) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_acc(n_acc + 1);
    #1;
    bus.req_valid[1] = 1'b0;
    drain();

    // Randomized traffic under three moduli.
    plist[0] = W'(97);
    plist[1] = p25519;
    plist[2] = pbig;
    for (int m = 0; m < 3; m++) begin
      bus.mod_p = plist[m];
      repeat (300) begin
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
          bus.req_valid[i]    = ($urandom_range(0, 3) != 0);
          bus.req_op[i]       = 1'($urandom_range(0, 1));
          bus.req_a[i*W +: W] = rnd_w() % plist[m];
          bus.req_b[i*W +: W] = rnd_w() % plist[m];
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      drain();
    end

    // Reset while in PASS2, then both requesters: rr must restart at 0.
    bus.mod_p = W'(97);
    issue(0, OP_ADD, W'(30), W'(40));
    issue(1, OP_ADD, W'(1), W'(2));
    drain();
    issue(0, OP_ADD, W'(30), W'(40));
    @(posedge clk); #1;
    chk("busy_before_rst", W'(bus.busy), W'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_op          = 2'b01;
    bus.req_a[0 +: W]   = W'(25);
    bus.req_b[0 +: W]   = W'(80);
    bus.req_a[W +: W]   = W'(96);
    bus.req_b[W +: W]   = W'(96);
    bus.req_valid       = '1;
    wait_acc(n_acc + 2);
    #1;
    bus.req_valid = '0;
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
